// File: rtl/uart_tx_feeder.sv
// Byte FIFO drained into a register-mapped UART: one init command after reset,
// then a status poll (bit4 = TX data register empty) before every data write.
module uart_tx_feeder #(
   parameter int unsigned DEPTH    = 16,
   parameter logic [7:0]  CMD_INIT = 8'h0B
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   flush,
   output logic                   uart_cs,
   output logic                   uart_rw,
   output logic                   uart_rs0,
   output logic                   uart_rs1,
   output logic [7:0]             uart_wdata,
   input  logic [7:0]             uart_rdata,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic                   busy
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_POLL, S_WAIT, S_WRITE} state_t;

   state_t        state_q, state_d;
   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   level_q, level_d;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic [1:0]    rs_sel;
   logic          unused_rdata;

   assign unused_rdata = ^{uart_rdata[7:5], uart_rdata[3:0]};

   assign fifo_empty = (level_q == '0);
   assign in_ready   = (level_q != LVL_FULL);
   assign push       = in_valid & in_ready & ~flush;
   // A flushed WRITE still drives its bus cycle, but the byte leaves no trace in the FIFO.
   assign pop        = (state_q == S_WRITE) & ~fifo_empty & ~flush;
   assign fifo_level = level_q;
   assign busy       = ~fifo_empty | (state_q != S_IDLE);

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= in_data;
      end
   end

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         level_d = '0;
      end else begin
         if (push) begin
            wptr_d = wptr_q + AW'(1);
         end
         if (pop) begin
            rptr_d = rptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_INIT;
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:  state_d = S_IDLE;
         S_IDLE:  if (!fifo_empty && !flush) state_d = S_POLL;
         S_POLL:  state_d = flush ? S_IDLE : S_WAIT;
         S_WAIT: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (uart_rdata[4]) begin
               state_d = S_WRITE;
            end else begin
               state_d = S_POLL;
            end
         end
         S_WRITE: state_d = S_IDLE;
         default: state_d = S_INIT;
      endcase
   end

   always_comb begin
      uart_cs    = 1'b0;
      uart_rw    = 1'b1;
      rs_sel     = 2'b00;
      uart_wdata = '0;
      case (state_q)
         S_INIT: begin
            uart_cs    = 1'b1;
            uart_rw    = 1'b0;
            rs_sel     = 2'b10;
            uart_wdata = CMD_INIT;
         end
         S_POLL: begin
            uart_cs = 1'b1;
            uart_rw = 1'b1;
            rs_sel  = 2'b01;
         end
         S_WRITE: begin
            uart_cs    = 1'b1;
            uart_rw    = 1'b0;
            rs_sel     = 2'b00;
            uart_wdata = mem_q[rptr_q];
         end
         default: ;
      endcase
   end

   assign uart_rs1 = rs_sel[1];
   assign uart_rs0 = rs_sel[0];

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a UART status model, a byte scoreboard filled on
// accepted pushes, and a negedge monitor that checks every data write.
module tb_uart_tx_feeder;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    in_data = 8'h00;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          flush = 1'b0;
   logic          uart_cs, uart_rw, uart_rs0, uart_rs1;
   logic [7:0]    uart_wdata;
   logic [7:0]    rdata_q = 8'h00;
   logic [LW-1:0] fifo_level;
   logic          busy;

   int checks = 0;
   int failures = 0;
   logic [7:0] exp_q[$];
   int mlevel = 0;
   int n_acc = 0;
   int n_wr = 0;
   int n_poll = 0;
   logic [7:0] status = 8'h10;
   logic wr_seen = 1'b0;
   logic poll_seen = 1'b0;

   uart_tx_feeder #(.DEPTH(DEPTH), .CMD_INIT(8'h0B)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .flush(flush), .uart_cs(uart_cs), .uart_rw(uart_rw),
      .uart_rs0(uart_rs0), .uart_rs1(uart_rs1), .uart_wdata(uart_wdata),
      .uart_rdata(rdata_q), .fifo_level(fifo_level), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // UART register model and reference FIFO accounting, both on the clock edge.
   always @(posedge clk) begin
      if (poll_seen) begin
         rdata_q <= status;
         n_poll++;
      end
      if (rst || flush) begin
         exp_q.delete();
         mlevel = 0;
      end else begin
         if (in_valid && mlevel != DEPTH) begin
            exp_q.push_back(in_data);
            n_acc++;
            mlevel++;
         end
         if (wr_seen && mlevel > 0) mlevel--;
      end
   end

   always @(negedge clk) begin
      logic [1:0] rs;
      logic [7:0] exp;
      rs = {uart_rs1, uart_rs0};
      wr_seen   = (uart_cs === 1'b1) && (uart_rw === 1'b0) && (rs === 2'b00);
      poll_seen = (uart_cs === 1'b1) && (uart_rw === 1'b1) && (rs === 2'b01);
      if (wr_seen) begin
         n_wr++;
         if (exp_q.size() == 0) begin
            chk("write_unexpected", 32'(uart_wdata), 32'hFFFF_FFFF);
         end else begin
            exp = exp_q.pop_front();
            chk("write_data", 32'(uart_wdata), 32'(exp));
         end
      end
      if ((uart_cs === 1'b1) && (uart_rw === 1'b1) && (rs === 2'b00))
         chk("read_reg00", 32'(rs), 32'h1);
      if (!rst && uart_cs !== 1'bx) begin
         chk("level", 32'(fifo_level), 32'(mlevel));
         chk("in_ready", 32'(in_ready), 32'(mlevel != DEPTH));
         if (mlevel != 0) chk("busy_nonempty", 32'(busy), 32'h1);
         if (uart_cs === 1'b0)
            chk("idle_bus", {21'b0, uart_rw, rs, uart_wdata}, {21'b0, 1'b1, 2'b00, 8'h00});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_bytes(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         tick();
         in_data  = base + 8'(i);
         in_valid = 1'b1;
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_poll(input string name);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = poll_seen;
      end
      chk(name, 32'(seen), 32'h1);
   endtask

   task automatic drain(input string name);
      logic done;
      done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         done = (fifo_level == '0) && !busy;
      end
      chk(name, 32'(done), 32'h1);
   endtask

   task automatic chk_init(input string name);
      chk(name, {27'b0, uart_cs, uart_rw, uart_rs1, uart_rs0, busy}, {27'b0, 5'b10101});
      chk({name, "_wdata"}, 32'(uart_wdata), 32'h0B);
   endtask

   initial begin
      int p0, w0, a0, guard;
      logic done;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_init("reset_init");
      chk("reset_level", 32'(fifo_level), 32'h0);
      chk("reset_ready", 32'(in_ready), 32'h1);
      @(negedge clk);
      chk("after_init_cs", 32'(uart_cs), 32'h0);
      chk("after_init_busy", 32'(busy), 32'h0);

      // single byte latency with TX empty on the first poll
      status = 8'h10;
      tick();
      in_data = 8'h41; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_e0_cs", 32'(uart_cs), 32'h0);
      @(negedge clk);
      chk("lat_poll", {28'b0, uart_cs, uart_rw, uart_rs1, uart_rs0}, 32'b1101);
      @(negedge clk);
      chk("lat_wait_cs", 32'(uart_cs), 32'h0);
      @(negedge clk);
      chk("lat_write", {28'b0, uart_cs, uart_rw, uart_rs1, uart_rs0}, 32'b1000);
      chk("lat_wdata", 32'(uart_wdata), 32'h41);
      @(negedge clk);
      chk("lat_level", 32'(fifo_level), 32'h0);
      chk("lat_busy", 32'(busy), 32'h0);

      // five busy polls before the transmitter frees up
      status = 8'h00;
      p0 = n_poll; w0 = n_wr;
      push_bytes(1, 8'h5A);
      for (int i = 0; i < 200 && (n_poll - p0) < 5; i++) @(negedge clk);
      chk("poll5_reached", 32'(n_poll - p0), 32'd5);
      status = 8'h10;
      done = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         done = (n_wr - w0) >= 1;
      end
      repeat (8) @(negedge clk);
      chk("poll_count", 32'(n_poll - p0), 32'd6);
      chk("single_write", 32'(n_wr - w0), 32'd1);

      // fill to DEPTH with TX held busy, extra offers must be refused
      status = 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
         tick();
         in_data = 8'(i); in_valid = 1'b1;
      end
      tick();
      in_data = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("full_ready", 32'(in_ready), 32'h0);
         chk("full_level", 32'(fifo_level), 32'(DEPTH));
      end
      tick();
      in_valid = 1'b0;
      status = 8'h10;
      drain("full_drain");

      // flush while waiting on the status read
      status = 8'h00;
      push_bytes(3, 8'hC0);
      wait_poll("flush_poll_seen");
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      status = 8'h10;
      w0 = n_wr;
      @(negedge clk);
      chk("flush_level", 32'(fifo_level), 32'h0);
      chk("flush_idle", {30'b0, uart_cs, busy}, 32'h0);
      repeat (10) @(negedge clk);
      chk("flush_no_write", 32'(n_wr - w0), 32'h0);

      // reset in the middle of a transfer
      status = 8'h00;
      push_bytes(2, 8'h90);
      wait_poll("rst_poll_seen");
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      status = 8'h10;
      w0 = n_wr;
      @(negedge clk);
      chk_init("rst_mid_init");
      repeat (15) @(negedge clk);
      chk("rst_mid_no_write", 32'(n_wr - w0), 32'h0);
      chk("rst_mid_level", 32'(fifo_level), 32'h0);

      // random streaming with intermittent busy status
      a0 = n_acc; w0 = n_wr; guard = 0;
      while ((n_acc - a0) < 1000 && guard < 20000) begin
         tick();
         guard++;
         in_valid = ($urandom_range(0, 9) < 7);
         in_data  = 8'($urandom);
         status   = 8'($urandom);
         status[4] = ($urandom_range(0, 7) != 0);
      end
      chk("rand_budget", 32'(guard < 20000), 32'h1);
      tick();
      in_valid = 1'b0;
      status = 8'h10;
      drain("rand_drain");
      chk("rand_all_written", 32'(n_wr - w0), 32'(n_acc - a0));
      chk("end_queue_empty", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-002 Parameter CMD_INIT, default 8'h0B, byte written once to the UART command register after reset.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port in_data  input  8  byte offered by the producer.
REQ-006 Port in_valid  input  1  producer has a byte on in_data.
REQ-007 Port in_ready  output  1  feeder accepts in_data this cycle.
REQ-008 Port flush  input  1  discard all queued bytes.
REQ-009 Port uart_cs  output  1  UART chip select, active high.
REQ-010 Port uart_rw  output  1  1=read, 0=write.
REQ-011 Port uart_rs0, uart_rs1  output  1 each  UART register select.
REQ-012 Port uart_wdata  output  8  data to UART data_in.
REQ-013 Port uart_rdata  input  8  UART data_out; registered by the UART, valid the cycle after a read strobe.
REQ-014 Port fifo_level  output  $clog2(DEPTH)+1  bytes queued.
REQ-015 Port busy  output  1  high when FIFO non-empty or state != IDLE.

Function
REQ-016 FIFO: circular buffer, read/write pointers wrap at DEPTH; level counter 0..DEPTH.
REQ-017 in_ready = (fifo_level != DEPTH), combinational; push on in_valid & in_ready at clock edge.
REQ-018 Full FIFO: in_ready low even if a pop occurs that cycle; no push, no data loss, no overflow flag.
REQ-019 Simultaneous push and pop (not full, not empty): level unchanged, both pointers advance.
REQ-020 FSM states: INIT, IDLE, POLL, WAIT, WRITE.
REQ-021 INIT: uart_cs=1, uart_rw=0, {rs1,rs0}=2'b10, uart_wdata=CMD_INIT; one cycle, then IDLE.
REQ-022 IDLE: uart_cs=0; if FIFO non-empty and flush low, next state POLL.
REQ-023 POLL: uart_cs=1, uart_rw=1, {rs1,rs0}=2'b01 (status); one cycle, then WAIT.
REQ-024 WAIT: uart_cs=0; sample uart_rdata[4] (transmit data register empty); 1 -> WRITE, 0 -> POLL.
REQ-025 WRITE: uart_cs=1, uart_rw=0, {rs1,rs0}=2'b00, uart_wdata=FIFO head; pop at this edge; next state IDLE.
REQ-026 Bus outputs decoded combinationally from state; when uart_cs=0, uart_rw=1, rs=2'b00, uart_wdata=8'h00.
REQ-027 Never read UART register 00 (read has side effects).
REQ-028 Latency: byte pushed into empty FIFO at edge E0 with FSM in IDLE appears on uart_wdata with write strobe during cycle E3..E4 when the first status poll returns bit4=1.
REQ-029 flush: pointers and level cleared at the edge; a push in the same cycle is dropped; POLL/WAIT go to IDLE; WRITE completes its bus write but the byte is discarded from accounting; INIT unaffected.
REQ-030 Bytes leave in push order; each byte written exactly once.

Reset
REQ-031 On rst: state INIT, pointers 0, fifo_level 0, in_ready 1, busy 1 (INIT), bus outputs per INIT in the first cycle after reset release.
REQ-032 rst mid-transfer aborts without further strobes other than INIT; queued bytes lost.

Verification
REQ-033 Reset release -> exactly one cycle cs=1, rw=0, rs=10, wdata=8'h0B; then idle, cs=0.
REQ-034 Push 8'h41 into empty FIFO, model UART returns status 8'h10 -> write of 8'h41 to rs=00 during cycle E3; level back to 0; busy low next cycle.
REQ-035 Status returns 8'h00 for 5 polls then 8'h10 -> POLL/WAIT alternate 5 times, single write afterward, no rs=00 read ever.
REQ-036 Push DEPTH bytes 0x00..0x0F with status held 8'h00 -> in_ready low, level 16, extra in_valid ignored; release status -> bytes emitted 0x00..0x0F in order.
REQ-037 Queue 3 bytes, assert flush during WAIT -> level 0, FSM IDLE, no write strobe follows.
REQ-038 Continuous push while draining (status 8'h10) -> level never exceeds DEPTH, no byte duplicated or lost over 1000 random bytes.
